// File: rtl/codificador_sequencia.sv
// codificador_sequencia: sequence encoder that emits only legal decoder codewords (optional abort via CODIFICADOR_ABORT_EN)
module codificador_sequencia #(
  parameter int GAP = 0
) (
  input  logic       clk,
  input  logic       Reset,
  input  logic [3:0] sym_in,
  input  logic       sym_valid,
  output logic       sym_ready,
  output logic [6:0] code_out,
  output logic       ctrl_out,
  output logic [3:0] state_out,
  output logic       err_pulse,
  output logic       done
);
  typedef enum logic [3:0] {
    S0 = 4'd0, S1 = 4'd1, S2 = 4'd2, S3 = 4'd3, S4 = 4'd4, S5 = 4'd5,
    SERR = 4'b1000, SA = 4'b1001, SB = 4'b1010
  } state_t;
  localparam logic [3:0] SYM_A = 4'b1001;
  localparam logic [3:0] SYM_B = 4'b1010;
  state_t     state, state_d;
  logic [6:0] code_d, cw;
  logic [3:0] gap, gap_d;
  logic       ctrl_d, err_d, legal, xfer;
  assign state_out = state;
  assign done      = (state == SA) | (state == SB);
  assign sym_ready = ~done & (state != SERR) & ~ctrl_out & (gap == 4'd0);
  assign xfer      = sym_valid & sym_ready;
  // adjacency rules and codeword lookup for the requested symbol
  always_comb begin
    legal = 1'b0;
    case (state)
      S0: legal = (sym_in >= 4'd1) && (sym_in <= 4'd5);
      S1: legal = (sym_in == 4'd2) || (sym_in == SYM_A);
      S2: legal = (sym_in == 4'd1) || (sym_in == 4'd3) || (sym_in == SYM_A);
      S3: legal = (sym_in == 4'd2) || (sym_in == 4'd4) || (sym_in == SYM_A);
      S4: legal = (sym_in == 4'd3) || (sym_in == 4'd5) || (sym_in == SYM_B);
      S5: legal = (sym_in == 4'd4) || (sym_in == SYM_B);
      default: legal = 1'b0;
    endcase
    cw = 7'b0000000;
    case (sym_in)
      4'd1:  cw = 7'b1100000;
      4'd2:  cw = 7'b1000100;
      4'd3:  cw = 7'b1111100;
      4'd4:  cw = 7'b1011010;
      4'd5:  cw = 7'b1101110;
      SYM_A: cw = 7'b1001001;
      SYM_B: cw = 7'b1010011;
      default: cw = 7'b0000000;
    endcase
  end
  // next shadow state, codeword, strobe, error pulse and gap countdown
  always_comb begin
    state_d = state;
    code_d  = code_out;
    ctrl_d  = 1'b0;
    err_d   = 1'b0;
    gap_d   = (gap == 4'd0) ? 4'd0 : gap - 4'd1;
    if (xfer && legal) begin
      state_d = state_t'(sym_in);
      code_d  = cw;
      ctrl_d  = 1'b1;
      gap_d   = GAP[3:0];
    end else if (xfer) begin
      err_d = 1'b1;
`ifdef CODIFICADOR_ABORT_EN
      if (state != S0) begin
        state_d = SERR;
        code_d  = 7'b1110101;
        ctrl_d  = 1'b1;
        gap_d   = GAP[3:0];
      end
`endif
    end
  end
  // registered outputs; reset wins over any simultaneous handshake
  always_ff @(posedge clk) begin
    if (Reset) begin
      state     <= S0;
      code_out  <= 7'b0;
      ctrl_out  <= 1'b0;
      err_pulse <= 1'b0;
      gap       <= 4'd0;
    end else begin
      state     <= state_d;
      code_out  <= code_d;
      ctrl_out  <= ctrl_d;
      err_pulse <= err_d;
      gap       <= gap_d;
    end
  end
endmodule

// File: tb/tb_codificador_sequencia.sv
// tb_codificador_sequencia: directed scoreboard bench for codificador_sequencia (GAP=0 and GAP=2 instances)
module tb_codificador_sequencia;
`ifdef CODIFICADOR_ABORT_EN
  localparam bit ABORT = 1'b1;
`else
  localparam bit ABORT = 1'b0;
`endif
  logic       clk = 1'b0;
  logic       Reset = 1'b1;
  logic [3:0] sym_in = 4'd0, sym2 = 4'd0;
  logic       sym_valid = 1'b0, valid2 = 1'b0;
  logic       sym_ready, ctrl_out, err_pulse, done;
  logic [6:0] code_out;
  logic [3:0] state_out;
  logic       ready2, ctrl2, err2, done2;
  logic [6:0] code2;
  logic [3:0] st2;
  typedef struct packed {logic ctrl; logic [6:0] code; logic [3:0] st; logic err;} exp_t;
  exp_t       q[$];
  int         n_assert = 0, n_fail = 0;
  logic [3:0] mst = 4'd0;
  logic [6:0] last_code = 7'd0;
  always #5 clk = ~clk;
  codificador_sequencia #(.GAP(0)) dut (
    .clk(clk), .Reset(Reset), .sym_in(sym_in), .sym_valid(sym_valid), .sym_ready(sym_ready),
    .code_out(code_out), .ctrl_out(ctrl_out), .state_out(state_out), .err_pulse(err_pulse), .done(done)
  );
  codificador_sequencia #(.GAP(2)) dut2 (
    .clk(clk), .Reset(Reset), .sym_in(sym2), .sym_valid(valid2), .sym_ready(ready2),
    .code_out(code2), .ctrl_out(ctrl2), .state_out(st2), .err_pulse(err2), .done(done2)
  );
  function automatic logic [6:0] cw(input logic [3:0] s);
    case (s)
      4'd1: return 7'b1100000;
      4'd2: return 7'b1000100;
      4'd3: return 7'b1111100;
      4'd4: return 7'b1011010;
      4'd5: return 7'b1101110;
      4'b1001: return 7'b1001001;
      4'b1010: return 7'b1010011;
      default: return 7'b0000000;
    endcase
  endfunction
  function automatic logic ok(input logic [3:0] st, input logic [3:0] s);
    if (st == 4'd0) return (s >= 4'd1) && (s <= 4'd5);
    if (st >= 4'd1 && st <= 4'd5) begin
      if (s >= 4'd1 && s <= 4'd5) return (s == st + 4'd1) || (s + 4'd1 == st);
      if (s == 4'b1001) return st <= 4'd3;
      if (s == 4'b1010) return st >= 4'd4;
    end
    return 1'b0;
  endfunction
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic do_reset();
    @(negedge clk);
    Reset = 1'b1; sym_valid = 1'b0; valid2 = 1'b0;
    @(negedge clk);
    @(negedge clk);
    Reset = 1'b0;
    mst = 4'd0; last_code = 7'd0;
  endtask
  task automatic send(input logic [3:0] s);
    exp_t e;
    int n = 0;
    @(negedge clk);
    sym_in = s; sym_valid = 1'b1;
    while (!sym_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("ready_wait", {31'b0, sym_ready}, 32'd1);
    if (ok(mst, s)) begin
      e.ctrl = 1'b1; e.code = cw(s); e.st = s; e.err = 1'b0;
    end else if (ABORT && mst != 4'd0) begin
      e.ctrl = 1'b1; e.code = 7'b1110101; e.st = 4'b1000; e.err = 1'b1;
    end else begin
      e.ctrl = 1'b0; e.code = last_code; e.st = mst; e.err = 1'b1;
    end
    q.push_back(e);
    mst = e.st; last_code = e.code;
    @(negedge clk);
    sym_valid = 1'b0;
    e = q.pop_front();
    chk("ctrl", {31'b0, ctrl_out}, {31'b0, e.ctrl});
    chk("code", {25'b0, code_out}, {25'b0, e.code});
    chk("state", {28'b0, state_out}, {28'b0, e.st});
    chk("err", {31'b0, err_pulse}, {31'b0, e.err});
    @(negedge clk);
    chk("strobe_len", {31'b0, ctrl_out}, 32'd0);
    chk("err_len", {31'b0, err_pulse}, 32'd0);
    chk("code_hold", {25'b0, code_out}, {25'b0, e.code});
  endtask
  initial begin
    do_reset();
    chk("rst_code", {25'b0, code_out}, 32'd0);
    chk("rst_ctrl", {31'b0, ctrl_out}, 32'd0);
    chk("rst_state", {28'b0, state_out}, 32'd0);
    chk("rst_err", {31'b0, err_pulse}, 32'd0);
    chk("rst_done", {31'b0, done}, 32'd0);
    chk("rst_ready", {31'b0, sym_ready}, 32'd1);
    send(4'd1); send(4'd2); send(4'd3); send(4'd4); send(4'd5); send(4'b1010);
    chk("done_B", {31'b0, done}, 32'd1);
    chk("state_B", {28'b0, state_out}, 32'hA);
    sym_in = 4'd4; sym_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("done_ready", {31'b0, sym_ready}, 32'd0);
      chk("done_noerr", {31'b0, err_pulse}, 32'd0);
      chk("done_noctrl", {31'b0, ctrl_out}, 32'd0);
    end
    do_reset();
    send(4'd1); send(4'd4);
    if (!ABORT) begin
      send(4'd2);
      chk("after_err_state", {28'b0, state_out}, 32'd2);
    end
    do_reset();
    send(4'd4); send(4'b1001);
    do_reset();
    send(4'd2); send(4'b1010);
    do_reset();
    send(4'd3); send(4'b1001);
    chk("A_ready", {31'b0, sym_ready}, 32'd0);
    chk("A_done", {31'b0, done}, 32'd1);
    do_reset();
    send(4'b1001); send(4'hF); send(4'd0);
    chk("s0_ready", {31'b0, sym_ready}, 32'd1);
    @(negedge clk);
    sym_in = 4'd1; sym_valid = 1'b1;
    @(negedge clk);
    chk("b2b_ctrl1", {31'b0, ctrl_out}, 32'd1);
    chk("b2b_ready_strobe", {31'b0, sym_ready}, 32'd0);
    sym_in = 4'd2;
    @(negedge clk);
    chk("b2b_ctrl0", {31'b0, ctrl_out}, 32'd0);
    @(negedge clk);
    sym_valid = 1'b0;
    chk("b2b_ctrl2", {31'b0, ctrl_out}, 32'd1);
    chk("b2b_code2", {25'b0, code_out}, 32'b1000100);
    mst = 4'd2; last_code = 7'b1000100;
    send(4'd3);
    @(negedge clk);
    sym_in = 4'd2; sym_valid = 1'b1;
    @(negedge clk);
    sym_valid = 1'b0;
    chk("rst_strobe_ctrl", {31'b0, ctrl_out}, 32'd1);
    Reset = 1'b1;
    @(negedge clk);
    chk("abort_rst_code", {25'b0, code_out}, 32'd0);
    chk("abort_rst_ctrl", {31'b0, ctrl_out}, 32'd0);
    chk("abort_rst_state", {28'b0, state_out}, 32'd0);
    Reset = 1'b0;
    mst = 4'd0; last_code = 7'd0;
    chk("abort_rst_ready", {31'b0, sym_ready}, 32'd1);
    do_reset();
    sym2 = 4'd1; valid2 = 1'b1;
    @(negedge clk);
    chk("gap_c1_ctrl", {31'b0, ctrl2}, 32'd1);
    chk("gap_c1_ready", {31'b0, ready2}, 32'd0);
    sym2 = 4'd2;
    @(negedge clk);
    chk("gap_c2_ctrl", {31'b0, ctrl2}, 32'd0);
    chk("gap_c2_ready", {31'b0, ready2}, 32'd0);
    @(negedge clk);
    chk("gap_c3_ctrl", {31'b0, ctrl2}, 32'd0);
    @(negedge clk);
    valid2 = 1'b0;
    chk("gap_c4_ctrl", {31'b0, ctrl2}, 32'd1);
    chk("gap_c4_code", {25'b0, code2}, 32'b1000100);
    chk("gap_c4_state", {28'b0, st2}, 32'd2);
    do_reset();
    send(4'd5); send(4'd2);
    if (ABORT) begin
      sym_in = 4'd4; sym_valid = 1'b1;
      for (int i = 0; i < 4; i++) begin
        @(negedge clk);
        chk("abort_stuck", {31'b0, sym_ready}, 32'd0);
      end
      sym_valid = 1'b0;
      do_reset();
      chk("abort_cleared", {31'b0, sym_ready}, 32'd1);
    end else begin
      chk("noabort_ready", {31'b0, sym_ready}, 32'd1);
      chk("noabort_state", {28'b0, state_out}, 32'd5);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
  initial begin
    #200000;
    $display("FAIL timeout: observed no finish expected finish");
    $fatal(1, "timeout");
  end
endmodule
